t_ff_count_ctrl: RTL and testbench

Sequencing controller for a bank of WIDTH T flip-flops used as a programmable synchronous counter. It computes the per-bit T enables each cycle to count up from 0 to a programmable limit, then clears the bank to 0. Clearing is done by toggling exactly the set bits. It supports free-run (wrap) and one-shot modes with a start/stop/done handshake, and is the block that drives T-flop counter banks in the design.

---
 rtl/t_ff_pkg.sv | 14 +
 rtl/t_ff_cell.sv | 14 +
 rtl/t_ff_count_ctrl.sv | 96 +++++++++
 tb/tb_t_ff_count_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/t_ff_pkg.sv
// Shared definitions for the T flip-flop counter bank controller.
// The package holds the controller state encoding and the mode constants.
package t_ff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_FREE    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/t_ff_cell.sv
// Single T flip-flop with synchronous active-high reset.
module t_ff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= q ^ t;
  end

endmodule

// File: rtl/t_ff_count_ctrl.sv
// Sequencing controller for a WIDTH-bit T flip-flop counter bank.
// Each cycle it produces per-bit toggle enables that count 0..limit and then clear the bank.
module t_ff_count_ctrl
  import t_ff_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             wrap,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] inc_mask;

  // Increment without an adder: bit i toggles when all lower bits are set.
  assign inc_mask[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_inc
    assign inc_mask[i] = &q[i-1:0];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    t_ff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t_vec[i]),
      .q   (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      limit_q <= '0;
      mode_q  <= MODE_FREE;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state and toggle enables; clearing toggles exactly the set bits (t_vec = q).
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    t_vec   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          t_vec   = q;
          limit_d = limit;
          mode_d  = mode;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (q == limit_q) begin
          t_vec  = q;
          wrap_d = 1'b1;
          if (mode_q == MODE_ONESHOT) state_d = ST_DONE;
        end else begin
          t_vec = inc_mask;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign wrap = wrap_q;

endmodule

// File: tb/tb_t_ff_count_ctrl.sv
// Scoreboard bench for t_ff_count_ctrl: directed scenarios followed by random traffic,
// checked against an arithmetic counter model.
module tb_t_ff_count_ctrl;

  localparam int unsigned W = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic         clk = 1'b0;
  logic         rst, start, stop, mode;
  logic [W-1:0] limit;
  logic [W-1:0] t_vec, q;
  logic         busy, wrap, done;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] tv;
    logic         busy;
    logic         wrap;
    logic         done;
  } obs_t;

  obs_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Model state: counter value, phase, captured settings and pending wrap pulse.
  int m_q = 0, m_st = M_IDLE, m_lim = 0, m_mode = 0;
  bit m_wrap = 1'b0;

  always #5 clk = ~clk;

  t_ff_count_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .limit (limit),
    .t_vec (t_vec),
    .q     (q),
    .busy  (busy),
    .wrap  (wrap),
    .done  (done)
  );

  // Monitor: every cycle the DUT presents its outputs; compare against the oldest prediction.
  always @(negedge clk) begin
    obs_t e, g;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      g = '{q: q, tv: t_vec, busy: busy, wrap: wrap, done: done};
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL cycle_outputs @%0d: got q=%h t_vec=%h busy=%b wrap=%b done=%b, expected q=%h t_vec=%h busy=%b wrap=%b done=%b",
                 cyc, g.q, g.tv, g.busy, g.wrap, g.done, e.q, e.tv, e.busy, e.wrap, e.done);
      end
    end
  end

  // Drive one cycle of inputs, predict this cycle's outputs, advance the model.
  task automatic cycle(input bit r, input bit s, input bit p, input bit md, input int lim);
    obs_t e;
    int   nq, nst, nlim, nmode;
    bit   nwrap;
    @(posedge clk);
    #1;
    cyc++;
    rst = r; start = s; stop = p; mode = md; limit = W'(lim);
    nq = m_q; nst = m_st; nlim = m_lim; nmode = m_mode; nwrap = 1'b0;
    case (m_st)
      M_IDLE: if (s && !p) begin
        nq = 0; nlim = lim; nmode = int'(md); nst = M_RUN;
      end
      M_RUN: if (p) begin
        nst = M_IDLE;
      end else if (m_q == m_lim) begin
        nq = 0; nwrap = 1'b1; nst = (m_mode == 1) ? M_DONE : M_RUN;
      end else begin
        nq = (m_q + 1) % (1 << W);
      end
      default: nst = M_IDLE;
    endcase
    e.q    = W'(m_q);
    e.tv   = W'(m_q ^ nq);
    e.busy = (m_st == M_RUN);
    e.wrap = m_wrap;
    e.done = (m_st == M_DONE);
    sb.push_back(e);
    if (r) begin
      nq = 0; nst = M_IDLE; nlim = 0; nmode = 0; nwrap = 1'b0;
    end
    m_q = nq; m_st = nst; m_lim = nlim; m_mode = nmode; m_wrap = nwrap;
  endtask

  // Cycles with start low and noise on the ignored inputs.
  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'($urandom), int'($urandom_range(0, 15)));
  endtask

  initial begin
    rst = 1'b1; start = 1'($urandom); stop = 1'($urandom);
    mode = 1'($urandom); limit = W'($urandom);
    @(posedge clk);
    cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)));
    idle(2);

    // One-shot, limit 3.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 3);
    idle(7);
    // Free-run, limit 2.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 2);
    idle(9);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
    idle(2);
    // Free-run full range.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 15);
    idle(20);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
    // Stop at q=5, restart, then start+stop together in IDLE.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 9);
    idle(5);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 9);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 4);
    idle(3);
    // One-shot, limit 0.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 0);
    idle(4);
    // Reset mid-run at q=6.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 9);
    idle(6);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(3);
    // Stop coincident with q==limit.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 3);
    idle(3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
    idle(3);

    // Random traffic, biased toward small limits so wraps and completions are frequent.
    for (int i = 0; i < 3000; i++) begin
      int lim;
      lim = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 15) == 0), 1'($urandom), lim);
    end

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d predictions left unchecked, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
